cai_comp_writer: RTL and testbench
==================================

Name: cai_comp_writer

Overview:
- Device-side producer of the CAI completion ring.
- Accepts completion tuples (tag, status, ext_status, bytes_written) from the Am95xx execution engine and buffers them in a small FIFO.
- Serialises each tuple into a 16-byte v1 completion record and writes it to host memory at comp_base + slot*16.
- Pulses comp_msg once each record is fully committed; this is the completion the host-side polling loop waits on.

Parameters:
- FIFO_DEPTH, 4, completion tuple buffer entries; power of two, ≥2.
- ADDR_W, 64, memory address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  ring enabled; when 0, no new record starts
- comp_base  in  ADDR_W  ring base byte address, 16-byte aligned
- comp_mask  in  32  ring slot mask (entries-1, power of two minus 1)
- ring_clear  in  1  one-cycle pulse: zero the producer index
- cmp_valid  in  1  completion tuple valid
- cmp_ready  out  1  FIFO can accept
- cmp_tag  in  32  submit tag echoed
- cmp_status  in  16  CAI status code
- cmp_ext  in  16  extended status
- cmp_bytes  in  32  bytes written by the op
- mem_req  out  1  word write request
- mem_addr  out  ADDR_W  byte address of word
- mem_wdata  out  32  little-endian word
- mem_wstrb  out  4  byte strobes, always 4'hF
- mem_ack  in  1  write accepted, same cycle as req or later
- mem_err  in  1  write failed; qualified by mem_ack
- comp_msg  out  1  one-cycle pulse per committed record
- prod_idx  out  32  records committed since clear
- fault  out  1  sticky: a record write saw mem_err
- busy  out  1  FSM not IDLE or FIFO non-empty
- cons_idx  in  32  host consumer index; used only with the optional feature

Behaviour:
- Reset (async, rst=1): FIFO empty, FSM IDLE, prod_idx=0, fault=0; all outputs 0 except cmp_ready=1. An in-flight mem_req drops immediately and the partial record is abandoned.
- FIFO push: occurs when cmp_valid & cmp_ready. cmp_ready = !full.
- Simultaneous push and pop are allowed when full, but cmp_ready still reads 0 when full (no bypass).
- Record layout:
  - word0 (offset 0) = tag
  - word1 (offset 4) = {ext, status}, status in the low half
  - word2 (offset 8) = bytes_written
  - word3 (offset 12) = 0
- Slot address = comp_base + ((prod_idx & comp_mask) << 4), computed at ADDR_W width and latched at record start.
- FSM states: IDLE, W0, W1, W2, W3, NOTIFY.
  - IDLE→W0: FIFO non-empty & enable (& not-full when the optional feature is enabled). The head entry is popped into a holding register on this transition.
  - Wn: mem_req=1 with stable addr/data until mem_ack. On ack, advance to W(n+1), or from W3 to NOTIFY.
  - mem_err on ack: fault←1, and the remaining words are still written (the slot is always fully overwritten).
  - NOTIFY: comp_msg=1 for exactly one cycle, prod_idx←prod_idx+1 (32-bit wrap), →IDLE.
- Minimum latency, FIFO push to comp_msg with mem_ack tied high: 7 cycles (push, IDLE, W0..W3, NOTIFY). Back-to-back records issue no extra idle cycle beyond IDLE.
- mem_req deasserts for at least 0 cycles between words. The address advances by 4 per word within a record.
- Slot wrap: index prod_idx & comp_mask, so slot comp_mask is followed by slot 0.
- enable falling mid-record: the current record completes and notifies; no new record starts.
- ring_clear:
  - In IDLE: prod_idx←0 next cycle.
  - In any other state: held pending and applied on NOTIFY exit, in which case prod_idx becomes 0, not +1.
  - Does not clear fault or the FIFO.
- fault clears only on rst.
- Config inputs (comp_base, comp_mask) are sampled only at record start.

Optional Feature:
- Macro: CARBON_CAI_COMP_BACKPRESSURE_EN.
- Defined: the ring counts as full when (prod_idx - cons_idx) > comp_mask (32-bit modular). In that case the FSM stays in IDLE and the FIFO holds entries, so cmp_ready eventually falls. The check is applied only at IDLE→W0.
- Undefined: cons_idx is ignored and the writer overwrites unconsumed slots.

Test Plan:
- Single record, base 0x4000, mask 0xFF, mem_ack tied 1, tuple {tag=0x1, status=0, ext=0, bytes=4}:
  - Writes to 0x4000/4/8/C = 0x00000001, 0x00000000, 0x00000004, 0x00000000.
  - comp_msg pulses once, 7 cycles after push; prod_idx=1.
- Wrap, mask=1, three tuples tags 0xA, 0xB, 0xC: records land at slots 0, 1, 0 (0x4000, 0x4010, 0x4000). Final word0 at 0x4000 = 0xC; prod_idx=3.
- FIFO full, FIFO_DEPTH=4, mem_ack held 0, 6 pushes attempted:
  - Entry 1 is popped into the FSM, so 5 are accepted and cmp_ready=0.
  - After ack is released, all 5 records are committed in order and comp_msg pulses 5 times.
- Error path, mem_err=1 on word1 ack only: all 4 words are still written, comp_msg pulses, fault=1 and stays 1 after the next good record.
- Reset mid-record, rst asserted while in W2 with mem_req=1:
  - mem_req=0 asynchronously in the same cycle, prod_idx=0, FIFO empty.
  - No comp_msg for the aborted record.
- Backpressure (macro on), mask=3, cons_idx=0:
  - 4 records commit, then the 5th stalls and mem_req stays 0.
  - Setting cons_idx=1 lets the 5th commit to slot 0 and prod_idx reaches 5.

Source files
------------

// File: rtl/cai_comp_writer.sv
// CAI completion ring producer: buffers completion tuples and writes each one as a 16-byte record.
// Optional ring-full backpressure against cons_idx is enabled by defining CARBON_CAI_COMP_BACKPRESSURE_EN.
module cai_comp_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] comp_base,
  input  logic [31:0]       comp_mask,
  input  logic              ring_clear,
  input  logic              cmp_valid,
  output logic              cmp_ready,
  input  logic [31:0]       cmp_tag,
  input  logic [15:0]       cmp_status,
  input  logic [15:0]       cmp_ext,
  input  logic [31:0]       cmp_bytes,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic              mem_err,
  output logic              comp_msg,
  output logic [31:0]       prod_idx,
  output logic              fault,
  output logic              busy,
  input  logic [31:0]       cons_idx
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] bytes;
    logic [15:0] ext;
    logic [15:0] status;
    logic [31:0] tag;
  } cmp_t;

  typedef enum logic [2:0] {S_IDLE, S_W0, S_W1, S_W2, S_W3, S_NOTIFY} state_t;

  cmp_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  cmp_t              hold, hold_nxt;
  state_t            state, state_nxt;
  logic              start, push, word_ack, ring_full, clear_pend;
  logic [ADDR_W-1:0] slot_addr, addr_nxt;
  logic [31:0]       wdata_nxt;

  assign push      = cmp_valid & cmp_ready;
  assign word_ack  = mem_req & mem_ack;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(start);
  assign slot_addr = comp_base + (ADDR_W'(prod_idx & comp_mask) << 4);

`ifdef CARBON_CAI_COMP_BACKPRESSURE_EN
  assign ring_full = (prod_idx - cons_idx) > comp_mask;
`else
  logic unused_cons;
  assign ring_full   = 1'b0;
  assign unused_cons = ^cons_idx;
`endif

  // Tuple storage; data words need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{bytes: cmp_bytes, ext: cmp_ext, status: cmp_status, tag: cmp_tag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state, record start, and the word that the next state will present.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      S_IDLE: begin
        if ((count != '0) && enable && !ring_full) begin
          start     = 1'b1;
          state_nxt = S_W0;
        end
      end
      S_W0:     if (mem_ack) state_nxt = S_W1;
      S_W1:     if (mem_ack) state_nxt = S_W2;
      S_W2:     if (mem_ack) state_nxt = S_W3;
      S_W3:     if (mem_ack) state_nxt = S_NOTIFY;
      S_NOTIFY: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    hold_nxt = start ? fifo_mem[rd_ptr] : hold;
    case (state_nxt)
      S_W0:    wdata_nxt = hold_nxt.tag;
      S_W1:    wdata_nxt = {hold_nxt.ext, hold_nxt.status};
      S_W2:    wdata_nxt = hold_nxt.bytes;
      default: wdata_nxt = 32'h0;
    endcase

    addr_nxt = mem_addr;
    if (start)                           addr_nxt = slot_addr;
    else if (word_ack && state != S_W3)  addr_nxt = mem_addr + ADDR_W'(4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold       <= '0;
      cmp_ready  <= 1'b1;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      comp_msg   <= 1'b0;
      fault      <= 1'b0;
      prod_idx   <= '0;
      clear_pend <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + PTR_W'(push);
      rd_ptr    <= rd_ptr + PTR_W'(start);
      count     <= count_nxt;
      hold      <= hold_nxt;
      cmp_ready <= (count_nxt != CNT_W'(FIFO_DEPTH));
      busy      <= (state_nxt != S_IDLE) || (count_nxt != '0);
      mem_req   <= state_nxt inside {S_W0, S_W1, S_W2, S_W3};
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_wstrb <= 4'hF;
      comp_msg  <= (state_nxt == S_NOTIFY);
      if (word_ack && mem_err) fault <= 1'b1;

      // A clear outside IDLE waits for the record to finish, then replaces the increment.
      if (state == S_NOTIFY) begin
        prod_idx   <= (clear_pend || ring_clear) ? 32'h0 : prod_idx + 32'd1;
        clear_pend <= 1'b0;
      end else if (ring_clear) begin
        if (state == S_IDLE) prod_idx   <= 32'h0;
        else                 clear_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cai_comp_writer.sv
// Directed self-checking bench for cai_comp_writer (default build; backpressure steps run when
// CARBON_CAI_COMP_BACKPRESSURE_EN is defined).
module tb_cai_comp_writer;

  logic        clk = 1'b0;
  logic        rst, enable, ring_clear, cmp_valid, cmp_ready;
  logic [63:0] comp_base, mem_addr;
  logic [31:0] comp_mask, cmp_tag, cmp_bytes, mem_wdata, prod_idx, cons_idx;
  logic [15:0] cmp_status, cmp_ext;
  logic        mem_req, mem_ack, mem_err, comp_msg, fault, busy;
  logic [3:0]  mem_wstrb;
  logic        ack_en, err_en;

  int n_chk = 0;
  int n_err = 0;
  int msg_cnt = 0;
  int cyc = 0;
  int bad_strb = 0;
  int msg_cyc[$];
  logic [63:0] wa[$];
  logic [31:0] wd[$];

  assign mem_ack = ack_en;
  assign mem_err = err_en && mem_req && (mem_addr[3:0] == 4'h4);

  always #5 clk = ~clk;

  cai_comp_writer #(.FIFO_DEPTH(4), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst), .enable(enable), .comp_base(comp_base), .comp_mask(comp_mask),
    .ring_clear(ring_clear), .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_tag(cmp_tag),
    .cmp_status(cmp_status), .cmp_ext(cmp_ext), .cmp_bytes(cmp_bytes), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_err(mem_err), .comp_msg(comp_msg), .prod_idx(prod_idx), .fault(fault), .busy(busy),
    .cons_idx(cons_idx)
  );

  // Host memory log and notification monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && mem_ack) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (comp_msg) begin
      msg_cnt <= msg_cnt + 1;
      msg_cyc.push_back(cyc);
    end
    if (mem_req && mem_wstrb != 4'hF) bad_strb <= bad_strb + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] tag, input logic [15:0] st, input logic [15:0] ex,
                      input logic [31:0] by);
    int w = 0;
    while (!cmp_ready && w < 100) begin
      tick();
      w++;
    end
    chk("push_ready", 64'(cmp_ready), 64'd1);
    cmp_tag = tag; cmp_status = st; cmp_ext = ex; cmp_bytes = by;
    cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
  endtask

  task automatic wait_msg(input int n, input string tag);
    int w = 0;
    while (msg_cnt < n && w < 300) begin
      tick();
      w++;
    end
    chk(tag, 64'(msg_cnt), 64'(n));
    tick();
  endtask

  initial begin
    int w, m0, acc, lat, cyc_n;
    logic found;
    rst = 1'b0; enable = 1'b0; comp_base = '0; comp_mask = '0; ring_clear = 1'b0;
    cmp_valid = 1'b0; cmp_tag = '0; cmp_status = '0; cmp_ext = '0; cmp_bytes = '0;
    cons_idx = '0; ack_en = 1'b0; err_en = 1'b0;
    #2 rst = 1'b1;
    tick(2);
    chk("rst_cmp_ready", 64'(cmp_ready), 64'd1);
    chk("rst_mem_req",   64'(mem_req),   64'd0);
    chk("rst_comp_msg",  64'(comp_msg),  64'd0);
    chk("rst_prod_idx",  64'(prod_idx),  64'd0);
    chk("rst_fault",     64'(fault),     64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_mem_addr",  mem_addr,       64'd0);
    rst = 1'b0; comp_base = 64'h4000; comp_mask = 32'hFF; enable = 1'b1; ack_en = 1'b1;
    tick(2);

    // Single record: push cycle is cycle 1, comp_msg is expected in cycle 7.
    w = wa.size(); m0 = msg_cnt; lat = 0;
    cmp_tag = 32'h1; cmp_status = 16'h0; cmp_ext = 16'h0; cmp_bytes = 32'h4; cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0; cyc_n = 2;
    for (int k = 0; k < 12; k++) begin
      if (comp_msg && lat == 0) lat = cyc_n;
      tick();
      cyc_n++;
    end
    chk("single_latency", 64'(lat), 64'd7);
    chk("single_nwrites", 64'(wa.size() - w), 64'd4);
    chk("single_a0", wa[w],   64'h4000); chk("single_d0", 64'(wd[w]),   64'h1);
    chk("single_a1", wa[w+1], 64'h4004); chk("single_d1", 64'(wd[w+1]), 64'h0);
    chk("single_a2", wa[w+2], 64'h4008); chk("single_d2", 64'(wd[w+2]), 64'h4);
    chk("single_a3", wa[w+3], 64'h400C); chk("single_d3", 64'(wd[w+3]), 64'h0);
    chk("single_msgs", 64'(msg_cnt - m0), 64'd1);
    chk("single_prod", 64'(prod_idx), 64'd1);

    // Clear in IDLE, then wrap with a two-slot ring.
    ring_clear = 1'b1;
    tick();
    ring_clear = 1'b0;
    chk("clear_idle_prod", 64'(prod_idx), 64'd0);
    comp_mask = 32'h1; w = wa.size();
    push(32'hA, 16'h0, 16'h0, 32'h10);
    push(32'hB, 16'h0, 16'h0, 32'h20);
    push(32'hC, 16'h0003, 16'h00C0, 32'h30);
    wait_msg(4, "wrap_msgs");
    chk("wrap_a_addr", wa[w],    64'h4000); chk("wrap_a_tag", 64'(wd[w]),   64'hA);
    chk("wrap_b_addr", wa[w+4],  64'h4010); chk("wrap_b_tag", 64'(wd[w+4]), 64'hB);
    chk("wrap_b_w1addr", wa[w+5], 64'h4014);
    chk("wrap_c_addr", wa[w+8],  64'h4000); chk("wrap_c_tag", 64'(wd[w+8]), 64'hC);
    chk("wrap_c_w1", 64'(wd[w+9]),  64'h00C00003);
    chk("wrap_c_w2", 64'(wd[w+10]), 64'h30);
    chk("wrap_prod", 64'(prod_idx), 64'd3);
    chk("b2b_spacing", 64'(msg_cyc[3] - msg_cyc[2]), 64'd6);

    // FIFO full with acks withheld: one entry sits in the FSM, four in the FIFO.
    comp_mask = 32'hFF; ack_en = 1'b0; w = wa.size(); acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmp_tag = 32'h101 + 32'(i); cmp_status = 16'h0; cmp_ext = 16'h0; cmp_bytes = 32'h8;
      cmp_valid = 1'b1;
      if (cmp_ready) acc++;
      tick();
    end
    cmp_valid = 1'b0;
    chk("full_accepted", 64'(acc), 64'd5);
    chk("full_ready",    64'(cmp_ready), 64'd0);
    chk("full_req_held", 64'(mem_req),   64'd1);
    chk("full_busy",     64'(busy),      64'd1);
    ack_en = 1'b1;
    wait_msg(9, "full_msgs");
    for (int i = 0; i < 5; i++) chk("full_order", 64'(wd[w+4*i]), 64'h101 + 64'(i));
    tick(5);
    chk("full_no_extra", 64'(msg_cnt), 64'd9);
    chk("full_ready_back", 64'(cmp_ready), 64'd1);
    chk("full_idle_busy", 64'(busy), 64'd0);
    chk("full_prod", 64'(prod_idx), 64'd8);

    // mem_err on word1 only: the slot is still fully written and fault sticks.
    w = wa.size(); err_en = 1'b1;
    push(32'h200, 16'h0, 16'h0, 32'h0);
    wait_msg(10, "err_msgs");
    err_en = 1'b0;
    chk("err_nwrites", 64'(wa.size() - w), 64'd4);
    chk("err_w3_addr", wa[w+3], 64'h408C);
    chk("err_fault", 64'(fault), 64'd1);
    push(32'h201, 16'h0, 16'h0, 32'h0);
    wait_msg(11, "err_good_msgs");
    chk("err_fault_sticky", 64'(fault), 64'd1);
    chk("err_prod", 64'(prod_idx), 64'd10);

    // Clear and enable drop mid-record: record finishes, index zeroes, next record waits.
    w = wa.size();
    push(32'h300, 16'h0, 16'h0, 32'h0);
    push(32'h301, 16'h0, 16'h0, 32'h0);
    enable = 1'b0; ring_clear = 1'b1;
    tick();
    ring_clear = 1'b0;
    wait_msg(12, "dis_msgs");
    tick(8);
    chk("dis_no_start", 64'(msg_cnt), 64'd12);
    chk("dis_req", 64'(mem_req), 64'd0);
    chk("dis_busy", 64'(busy), 64'd1);
    chk("dis_prod_clr", 64'(prod_idx), 64'd0);
    chk("dis_addr", wa[w], 64'h40A0);
    enable = 1'b1;
    wait_msg(13, "en_msgs");
    chk("en_prod", 64'(prod_idx), 64'd1);
    chk("en_addr", wa[w+4], 64'h4000);
    chk("en_tag", 64'(wd[w+4]), 64'h301);

    // Reset while in W2: request drops at once, no notification follows.
    push(32'h400, 16'h0, 16'h0, 32'h0);
    push(32'h401, 16'h0, 16'h0, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mem_req && mem_addr[3:0] == 4'h8) found = 1'b1;
      else tick();
    end
    chk("rstmid_reach_w2", 64'(found), 64'd1);
    m0 = msg_cnt; w = wa.size();
    rst = 1'b1;
    #1;
    chk("rstmid_req", 64'(mem_req), 64'd0);
    chk("rstmid_prod", 64'(prod_idx), 64'd0);
    chk("rstmid_fault", 64'(fault), 64'd0);
    chk("rstmid_ready", 64'(cmp_ready), 64'd1);
    chk("rstmid_busy", 64'(busy), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(15);
    chk("rstmid_no_msg", 64'(msg_cnt), 64'(m0));
    chk("rstmid_no_write", 64'(wa.size()), 64'(w));

`ifdef CARBON_CAI_COMP_BACKPRESSURE_EN
    // Four-slot ring with nothing consumed: the fifth record stalls until cons_idx moves.
    comp_mask = 32'h3; cons_idx = 32'h0; m0 = msg_cnt;
    for (int i = 0; i < 5; i++) push(32'h500 + 32'(i), 16'h0, 16'h0, 32'h0);
    wait_msg(m0 + 4, "bp_four");
    tick(20);
    chk("bp_stall_msgs", 64'(msg_cnt), 64'(m0 + 4));
    chk("bp_stall_req", 64'(mem_req), 64'd0);
    chk("bp_stall_prod", 64'(prod_idx), 64'd4);
    w = wa.size();
    cons_idx = 32'h1;
    wait_msg(m0 + 5, "bp_fifth");
    chk("bp_prod", 64'(prod_idx), 64'd5);
    chk("bp_addr", wa[w], 64'h4000);
    chk("bp_tag", 64'(wd[w]), 64'h504);
`endif

    chk("wstrb_always_f", 64'(bad_strb), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
